bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Arbitrates the KS-10 backplane bus between up to NREQ requesters: requester 0 is the CPU, the rest are the UBA/DMA ports. It grants one requester at a time and drives the single bus request. It returns a per-requester acknowledge, or a per-requester NXM abort if the selected device never acknowledges. It also supports locked (read-modify-write) sequences that keep the grant across consecutive cycles.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8); index 0 is the CPU.
- TIMEOUT, 15, maximum cycles in BUSY without busACKI before NXM abort (≥2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- reqI  in  NREQ  per-requester bus request; held high until that requester sees ackO or nxmO.
- lockI  in  NREQ  per-requester lock; when high at acknowledge time, the grant is retained.
- gntO  out  NREQ  one-hot grant; selects the bus address/data mux; all-zero when idle.
- busREQO  out  1  bus cycle request to the backplane.
- busACKI  in  1  backplane acknowledge from the addressed device.
- ackO  out  NREQ  one-cycle acknowledge to the granted requester.
- nxmO  out  NREQ  one-cycle non-existent-memory abort to the granted requester.
- nxmINTR  out  1  one-cycle NXM interrupt pulse to the CPU (OR of nxmO).
- busyO  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, BUSY, HOLD.
- IDLE: when reqI≠0, select a winner, register it into gntO, load the timer with TIMEOUT, and go to BUSY. When reqI=0, gntO=0.
- BUSY: busREQO=1 and gntO is held.
  - On busACKI=1: ackO[owner]=1 combinationally in the same cycle.
  - If lockI[owner]=1 that cycle, next state is HOLD; otherwise next state is IDLE and gntO clears.
  - On busACKI=0: the timer decrements. If the timer==1 and busACKI=0: nxmO[owner]=1 and nxmINTR=1 that cycle, next state is IDLE, gntO clears. A locked sequence is abandoned on NXM.
- HOLD: gntO is held, busREQO=0, and there is no timeout.
  - If reqI[owner]=1, reload the timer and go to BUSY with no rearbitration.
  - Else if lockI[owner]=0, go to IDLE.
  - Other requesters wait.
- Winner selection is per Configuration. The grant is always one-hot, and only requesters with reqI=1 are eligible.
- ackO and nxmO are never asserted together. At most one bit of each is set, and only for the owner.
- reqI deassertion by the owner during BUSY is illegal; the cycle still completes or times out.
- Timer width is clog2(TIMEOUT+1) bits, unsigned. Its value never wraps below 1 in BUSY.

## Timing
- Reset (rst=0 at an edge): state=IDLE, gntO=0, busREQO=0, ackO=0, nxmO=0, nxmINTR=0, busyO=0, timer=0, RR pointer=NREQ-1 (so requester 0 wins first).
- Reset mid-cycle: grant and busREQO drop at that edge; no ackO or nxmO is emitted for the aborted cycle.
- Request to bus: reqI seen in IDLE at edge N → gntO and busREQO high during cycle N+1.
- Acknowledge: ackO is coincident with busACKI. With no lock, busREQO and gntO are low the following cycle, and a new grant is possible one cycle after that (one IDLE turnaround).
- Timeout: with no busACKI, BUSY lasts exactly TIMEOUT cycles; nxmO pulses in the TIMEOUT-th cycle.
- Simultaneous busACKI and timer==1: the acknowledge wins; there is no NXM.
- busACKI in IDLE or HOLD is ignored.

## Configuration
- BUSARB_RR_EN defined: round-robin. The search starts at (last winner+1) mod NREQ; the pointer updates when a grant is issued from IDLE. HOLD re-entries do not move the pointer.
- Undefined: fixed priority, lowest index wins, so the CPU (0) always preempts DMA at arbitration points. There is no pointer register.

## Test plan
- Single CPU request, busACKI after 3 BUSY cycles → gntO=0001 and busREQO high for 3 cycles, ackO=0001 for one cycle, back to IDLE, nxmINTR never set.
- Requester 2, no busACKI (TIMEOUT=15) → busREQO high exactly 15 cycles, nxmO=0100 and nxmINTR pulse in cycle 15, gntO=0 next cycle.
- busACKI arrives in the same cycle the timer==1 → ackO pulses, nxmO/nxmINTR stay 0.
- reqI=1111 held, each cycle acked immediately → with BUSARB_RR_EN, grants 0,1,2,3,0…; without it, grant stays 0 every arbitration.
- Requester 1 with lockI=1: two acked cycles → gntO=0010 held through HOLD, requester 0 request ignored until lockI drops, then the CPU is granted.
- rst=0 asserted during BUSY → next edge all outputs 0, no ack or nxm pulse; after release, a pending request is granted normally.

Source files
------------

// File: rtl/bus_arbiter.sv
// KS-10 backplane bus arbiter: one-hot grant, bus request, ack/NXM return, locked RMW hold.
// Define BUSARB_RR_EN for round-robin arbitration; fixed priority (lowest index wins) otherwise.
module bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] reqI,
  input  logic [NREQ-1:0] lockI,
  output logic [NREQ-1:0] gntO,
  output logic            busREQO,
  input  logic            busACKI,
  output logic [NREQ-1:0] ackO,
  output logic [NREQ-1:0] nxmO,
  output logic            nxmINTR,
  output logic            busyO
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt, gnt_nxt, win, ack, nxm;
  logic [TW-1:0]   timer, timer_nxt;
  logic            owner_req, owner_lock;

  assign owner_req  = |(reqI & gnt);
  assign owner_lock = |(lockI & gnt);

`ifdef BUSARB_RR_EN
  localparam logic [NREQ-1:0] LAST_RST = {1'b1, {(NREQ-1){1'b0}}};
  logic [NREQ-1:0] last;

  // One-hot pointer to the last winner; search begins one position above it.
  always_comb begin
    logic [NREQ-1:0] cand;
    win  = '0;
    cand = {last[NREQ-2:0], last[NREQ-1]};
    for (int i = 0; i < NREQ; i++) begin
      if (win == '0 && (reqI & cand) != '0) win = cand;
      cand = {cand[NREQ-2:0], cand[NREQ-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                           last <= LAST_RST;
    else if (state == IDLE && reqI != '0) last <= win;
  end
`else
  always_comb begin
    logic [NREQ-1:0] cand;
    win  = '0;
    cand = ONE;
    for (int i = 0; i < NREQ; i++) begin
      if (win == '0 && (reqI & cand) != '0) win = cand;
      cand = cand << 1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    timer_nxt = timer;
    ack       = '0;
    nxm       = '0;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (reqI != '0) begin
          gnt_nxt   = win;
          timer_nxt = TW'(TIMEOUT);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // Acknowledge takes precedence over an expiring timer.
        if (busACKI) begin
          ack = gnt;
          if (owner_lock) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
          end
        end else if (timer == TW'(1)) begin
          nxm       = gnt;
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      HOLD: begin
        if (owner_req) begin
          timer_nxt = TW'(TIMEOUT);
          state_nxt = BUSY;
        end else if (!owner_lock) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // A cycle being aborted by reset reports neither ack nor NXM.
  assign ackO    = ack & {NREQ{rst}};
  assign nxmO    = nxm & {NREQ{rst}};
  assign nxmINTR = |nxmO;
  assign gntO    = gnt;
  assign busREQO = (state == BUSY);
  assign busyO   = (state != IDLE);
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a response scoreboard; follows BUSARB_RR_EN if defined.
module tb_bus_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NREQ-1:0] reqI = '0;
  logic [NREQ-1:0] lockI = '0;
  logic            busACKI = 1'b0;
  logic [NREQ-1:0] gntO, ackO, nxmO;
  logic            busREQO, nxmINTR, busyO;

  bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .reqI(reqI), .lockI(lockI), .gntO(gntO),
    .busREQO(busREQO), .busACKI(busACKI), .ackO(ackO), .nxmO(nxmO),
    .nxmINTR(nxmINTR), .busyO(busyO)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0] ack;
    logic [NREQ-1:0] nxm;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   rr_last  = NREQ - 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Reference arbitration choice; tracks the last winner for round-robin.
  function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] req);
    logic [NREQ-1:0] w;
    w = '0;
`ifdef BUSARB_RR_EN
    for (int i = 1; i <= NREQ; i++) begin
      int k;
      k = (rr_last + i) % NREQ;
      if (w == '0 && |(req & (NREQ'(1) << k))) begin
        w = NREQ'(1) << k;
        rr_last = k;
      end
    end
`else
    for (int k = NREQ - 1; k >= 0; k--)
      if (|(req & (NREQ'(1) << k))) w = NREQ'(1) << k;
`endif
    return w;
  endfunction

  task automatic push(input logic [NREQ-1:0] a, input logic [NREQ-1:0] n);
    exp_t e;
    e.ack = a;
    e.nxm = n;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l, input logic a);
    reqI    = r;
    lockI   = l;
    busACKI = a;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [NREQ-1:0] g, input logic breq, input logic busy);
    chk({tag, "_gnt"},    32'(gntO),    32'(g));
    chk({tag, "_busreq"}, 32'(busREQO), 32'(breq));
    chk({tag, "_busy"},   32'(busyO),   32'(busy));
  endtask

  // Every ack/NXM pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    #2;
    chk("ack_nxm_excl", 32'(ackO & nxmO), 32'h0);
    chk("nxm_intr", 32'(nxmINTR), 32'(|nxmO));
    if ((ackO | nxmO) != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'({ackO, nxmO}), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_ack", 32'(ackO), 32'(e.ack));
        chk("resp_nxm", 32'(nxmO), 32'(e.nxm));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] w4 [5];

    // Reset state
    repeat (2) cyc();
    drive('0, '0, 1'b0);
    expect_out("rst", '0, 1'b0, 1'b0);
    chk("rst_ack", 32'(ackO), 32'h0);
    chk("rst_nxm", 32'(nxmO), 32'h0);
    chk("rst_intr", 32'(nxmINTR), 32'h0);

    // CPU request, acked in the third BUSY cycle
    cyc(); rst = 1'b1; drive(4'b0001, '0, 1'b0);
    push(pick(4'b0001), '0);
    expect_out("t1_idle", '0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      cyc(); drive(4'b0001, '0, k == 3);
      expect_out("t1_busy", 4'b0001, 1'b1, 1'b1);
      chk("t1_ack", 32'(ackO), (k == 3) ? 32'h1 : 32'h0);
    end
    cyc(); drive('0, '0, 1'b0);
    expect_out("t1_done", '0, 1'b0, 1'b0);

    // Requester 2 with no acknowledge: NXM in the TIMEOUT-th BUSY cycle
    cyc(); drive(4'b0100, '0, 1'b0);
    push('0, pick(4'b0100));
    for (int k = 1; k <= TIMEOUT; k++) begin
      cyc(); drive(4'b0100, '0, 1'b0);
      expect_out("t2_busy", 4'b0100, 1'b1, 1'b1);
      chk("t2_nxm", 32'(nxmO), (k == TIMEOUT) ? 32'h4 : 32'h0);
      chk("t2_intr", 32'(nxmINTR), (k == TIMEOUT) ? 32'h1 : 32'h0);
    end
    cyc(); drive('0, '0, 1'b0);
    expect_out("t2_done", '0, 1'b0, 1'b0);

    // Acknowledge coincident with timer==1 wins over NXM
    cyc(); drive(4'b0100, '0, 1'b0);
    push(pick(4'b0100), '0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      cyc(); drive(4'b0100, '0, k == TIMEOUT);
      expect_out("t3_busy", 4'b0100, 1'b1, 1'b1);
      chk("t3_ack", 32'(ackO), (k == TIMEOUT) ? 32'h4 : 32'h0);
      chk("t3_nxm", 32'(nxmO), 32'h0);
    end
    cyc(); drive('0, '0, 1'b0);
    expect_out("t3_done", '0, 1'b0, 1'b0);

    // Locked sequence by requester 1; CPU waits until the lock drops
    cyc(); drive(4'b0010, 4'b0010, 1'b0);
    push(pick(4'b0010), '0);
    push(4'b0010, '0);
    cyc(); drive(4'b0011, 4'b0010, 1'b1);
    expect_out("t5_b1", 4'b0010, 1'b1, 1'b1);
    cyc(); drive(4'b0001, 4'b0010, 1'b0);
    expect_out("t5_hold", 4'b0010, 1'b0, 1'b1);
    cyc(); drive(4'b0011, 4'b0010, 1'b0);
    expect_out("t5_hold2", 4'b0010, 1'b0, 1'b1);
    cyc(); drive(4'b0011, 4'b0010, 1'b1);
    expect_out("t5_b2", 4'b0010, 1'b1, 1'b1);
    cyc(); drive(4'b0001, '0, 1'b0);
    expect_out("t5_hold3", 4'b0010, 1'b0, 1'b1);
    cyc(); drive(4'b0001, '0, 1'b0);
    expect_out("t5_idle", '0, 1'b0, 1'b0);
    push(pick(4'b0001), '0);
    cyc(); drive(4'b0001, '0, 1'b1);
    expect_out("t5_cpu", 4'b0001, 1'b1, 1'b1);
    cyc(); drive('0, '0, 1'b0);
    expect_out("t5_done", '0, 1'b0, 1'b0);

    // Reset in the middle of a BUSY cycle, then a normal regrant
    cyc(); drive(4'b1000, '0, 1'b0);
    w4[0] = pick(4'b1000);
    cyc(); drive(4'b1000, '0, 1'b0);
    expect_out("t6_busy", w4[0], 1'b1, 1'b1);
    rst = 1'b0;
    cyc(); drive(4'b1000, '0, 1'b0);
    expect_out("t6_rst", '0, 1'b0, 1'b0);
    chk("t6_rst_ack", 32'(ackO), 32'h0);
    chk("t6_rst_nxm", 32'(nxmO), 32'h0);
    rst = 1'b1;
    rr_last = NREQ - 1;
    push(pick(4'b1000), '0);
    cyc(); drive(4'b1000, '0, 1'b1);
    expect_out("t6_regrant", 4'b1000, 1'b1, 1'b1);
    cyc(); drive('0, '0, 1'b0);
    expect_out("t6_done", '0, 1'b0, 1'b0);

    // All requesting, every cycle acked immediately
    cyc(); drive(4'b1111, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      w4[i] = pick(4'b1111);
      push(w4[i], '0);
    end
    for (int k = 1; k <= 9; k++) begin
      cyc(); drive(4'b1111, '0, 1'b1);
      if (k % 2 == 1) expect_out("t4_busy", w4[(k - 1) / 2], 1'b1, 1'b1);
      else            expect_out("t4_idle", '0, 1'b0, 1'b0);
    end
    cyc(); drive('0, '0, 1'b0);
    expect_out("t4_done", '0, 1'b0, 1'b0);

    repeat (2) cyc();
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
